// File: rtl/program_loader.sv
// program_loader: assembles a checksummed byte stream into 32-bit words in the CPU instruction memory and gates cpu_run on a verified load
module program_loader #(
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter logic [7:0] MAX_OPCODE = 8'h0B
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          cpu_run,
  output logic          busy,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [AW:0]   words_loaded
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [AW:0] n;
  logic [1:0] byte_cnt;
  logic [23:0] shreg;
  logic [7:0] csum;
  logic acc, go, hdr_bad, op_bad, wr, last;
  assign busy = state inside {HDR, DATA, CHK};
  assign in_ready = busy;
  assign cpu_run = state == DONE;
  assign error = state == ERR;
  assign fetch_instr = mem[fetch_addr];
  assign acc = in_valid && in_ready;
  assign go = start && !busy;
  assign hdr_bad = in_byte == 8'd0 || in_byte > 8'(DEPTH);
  assign op_bad = byte_cnt == 2'd0 && in_byte > MAX_OPCODE;
  assign wr = acc && state == DATA && byte_cnt == 2'd3;
  assign last = words_loaded + (AW+1)'(1) == n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (go) state_nx = HDR;
    else if (acc)
      case (state)
        HDR:     state_nx = hdr_bad ? ERR : DATA;
        DATA:    state_nx = op_bad ? ERR : (wr && last) ? CHK : DATA;
        CHK:     state_nx = in_byte == csum ? DONE : ERR;
        default: state_nx = state;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n <= '0;
      byte_cnt <= '0;
      shreg <= '0;
      csum <= '0;
      err_code <= '0;
      words_loaded <= '0;
    end else if (go) begin
      err_code <= '0;
      words_loaded <= '0;
      csum <= '0;
      byte_cnt <= '0;
    end else if (acc) begin
      if (state == HDR) begin
        n <= in_byte[AW:0];
        csum <= in_byte;
        if (hdr_bad) err_code <= 2'd1;
      end else if (state == DATA) begin
        csum <= csum ^ in_byte;
        shreg <= {shreg[15:0], in_byte};
        byte_cnt <= byte_cnt + 2'd1;
        if (op_bad) err_code <= 2'd2;
        if (wr) words_loaded <= words_loaded + (AW+1)'(1);
      end else if (state == CHK && in_byte != csum) err_code <= 2'd3;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr) mem[words_loaded[AW-1:0]] <= {shreg, in_byte};
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed table and sequence checks of program_loader
module tb_program_loader;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0] in_byte = 0;
  logic in_ready, cpu_run, busy, error;
  logic [4:0] fetch_addr = 0;
  logic [31:0] fetch_instr;
  logic [1:0] err_code;
  logic [5:0] words_loaded;
  int checks = 0, failures = 0;
  logic [31:0] exp_mem [32];
  typedef struct packed {
    logic [79:0] bytes;
    logic [3:0]  len;
    logic        run, err;
    logic [1:0]  code;
    logic [5:0]  wl;
    logic [1:0]  we;
    logic [31:0] w0, w1;
  } vec_t;
  vec_t tbl [6];
  program_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .cpu_run(cpu_run), .busy(busy), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic chk_status(input string nm, input logic run, input logic err, input logic [1:0] code, input logic [5:0] wl);
    chk({nm, ".cpu_run"}, 32'(cpu_run), 32'(run));
    chk({nm, ".error"}, 32'(error), 32'(err));
    chk({nm, ".err_code"}, 32'(err_code), 32'(code));
    chk({nm, ".words_loaded"}, 32'(words_loaded), 32'(wl));
    chk({nm, ".busy"}, 32'(busy), 32'(0));
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(0));
  endtask
  task automatic mem_check(input string nm);
    for (int i = 0; i < 32; i++) begin
      fetch_addr = 5'(i);
      #1;
      chk($sformatf("%s.mem[%0d]", nm, i), fetch_instr, exp_mem[i]);
    end
    @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    in_valid = 1;
    in_byte = b;
    @(negedge clk);
    in_valid = 0;
  endtask
  function automatic logic [31:0] word_of(input int i);
    return {8'(i % 12), 8'(i), 8'(i * 7), 8'h5A ^ 8'(i)};
  endfunction
  task automatic load32(input int maxgap);
    logic [7:0] cs;
    logic [31:0] w;
    pulse_start();
    send(8'd32, $urandom_range(0, maxgap));
    cs = 8'd32;
    for (int i = 0; i < 32; i++) begin
      w = word_of(i);
      for (int k = 3; k >= 0; k--) begin
        send(w[8*k +: 8], $urandom_range(0, maxgap));
        cs ^= w[8*k +: 8];
      end
    end
    send(cs, $urandom_range(0, maxgap));
  endtask
  initial begin
    tbl[0] = '{80'h0201000000020A00010A, 4'd10, 1'b1, 1'b0, 2'd0, 6'd2, 2'b11, 32'h01000000, 32'h020A0001};
    tbl[1] = '{80'h00000000000000000000, 4'd1,  1'b0, 1'b1, 2'd1, 6'd0, 2'b00, 32'h0, 32'h0};
    tbl[2] = '{80'h21000000000000000000, 4'd1,  1'b0, 1'b1, 2'd1, 6'd0, 2'b00, 32'h0, 32'h0};
    tbl[3] = '{80'h02040301020C00000000, 4'd6,  1'b0, 1'b1, 2'd2, 6'd1, 2'b01, 32'h04030102, 32'h0};
    tbl[4] = '{80'h01081F0000FF00000000, 4'd6,  1'b0, 1'b1, 2'd3, 6'd1, 2'b01, 32'h081F0000, 32'h0};
    tbl[5] = '{80'h01081F00001600000000, 4'd6,  1'b1, 1'b0, 2'd0, 6'd1, 2'b01, 32'h081F0000, 32'h0};
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    repeat (2) @(negedge clk);
    chk_status("reset", 1'b0, 1'b0, 2'd0, 6'd0);
    rst_n = 1;
    mem_check("reset");
    for (int v = 0; v < 6; v++) begin
      pulse_start();
      for (int i = 0; i < int'(tbl[v].len); i++) send(tbl[v].bytes[79-8*i -: 8], 0);
      chk_status($sformatf("vec%0d", v), tbl[v].run, tbl[v].err, tbl[v].code, tbl[v].wl);
      if (tbl[v].we[0]) exp_mem[0] = tbl[v].w0;
      if (tbl[v].we[1]) exp_mem[1] = tbl[v].w1;
      mem_check($sformatf("vec%0d", v));
    end
    pulse_start();
    send(8'h01, 0);
    send(8'h05, 0);
    pulse_start();
    send(8'h06, 0);
    send(8'h07, 0);
    send(8'h08, 0);
    send(8'h0D, 0);
    chk_status("start_mid", 1'b1, 1'b0, 2'd0, 6'd1);
    exp_mem[0] = 32'h05060708;
    mem_check("start_mid");
    in_valid = 1;
    in_byte = 8'h01;
    repeat (3) @(negedge clk);
    in_valid = 0;
    chk_status("drop", 1'b1, 1'b0, 2'd0, 6'd1);
    load32(0);
    chk_status("load32", 1'b1, 1'b0, 2'd0, 6'd32);
    for (int i = 0; i < 32; i++) exp_mem[i] = word_of(i);
    mem_check("load32");
    pulse_start();
    send(8'h02, 0);
    send(8'h05, 0);
    send(8'h06, 0);
    send(8'h07, 0);
    send(8'h08, 0);
    send(8'h03, 0);
    send(8'h05, 0);
    #2 rst_n = 0;
    #1;
    chk_status("rst_mid", 1'b0, 1'b0, 2'd0, 6'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    mem_check("rst_mid");
    load32(3);
    chk_status("gaps", 1'b1, 1'b0, 2'd0, 6'd32);
    for (int i = 0; i < 32; i++) exp_mem[i] = word_of(i);
    mem_check("gaps");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
